rv_alu_issue: RTL and testbench

Pipelined issue/retire controller that sits in front of the RISC-V ALU and drives its control inputs. It accepts RV32I OP and OP-IMM instruction words with their source operands over a valid/ready handshake, and decodes each into operand values, pre-op bits (nx ix sx ny iy sy) and a 4-bit ALU opcode. It then captures the combinational ALU result and flag, and returns them with the destination register over a second valid/ready handshake.

---
 rtl/rv_alu_pkg.sv | 36 +++
 rtl/rv_alu_decode.sv | 95 +++++++++
 rtl/rv_alu_issue.sv | 112 +++++++++++
 tb/tb_rv_alu_issue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared definitions for the RV32I ALU issue path: ALU opcodes, major opcodes,
// and the packed ALU control word (pre-op bits plus operation).
package rv_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_EQ   = 4'd7;
    localparam logic [3:0] ALU_NE   = 4'd8;
    localparam logic [3:0] ALU_GE   = 4'd9;
    localparam logic [3:0] ALU_GEU  = 4'd10;
    localparam logic [3:0] ALU_AND  = 4'd11;
    localparam logic [3:0] ALU_OR   = 4'd12;
    localparam logic [3:0] ALU_XOR  = 4'd13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic       nx;
        logic       ix;
        logic       sx;
        logic       ny;
        logic       iy;
        logic       sy;
        logic [3:0] opcode;
    } alu_ctrl_t;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational RV32I OP/OP-IMM decode into ALU operands and control word.
// Unsupported encodings zero the operands/controls and raise illegal.
module rv_alu_decode
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y,
    output alu_ctrl_t       ctrl,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_base;
    logic       f7_alt;

    assign opc     = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);
    assign rd      = instr[11:7];

    always_comb begin
        x       = rs1;
        y       = rs2;
        ctrl    = '0;
        illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        ctrl.opcode = ALU_ADD;
                        // SUB is ADD with y negated by the ALU's invert+increment.
                        if (f7_alt) begin
                            ctrl.ny = 1'b1;
                            ctrl.iy = 1'b1;
                        end else if (!f7_base) begin
                            illegal = 1'b1;
                        end
                    end
                    3'b001: begin ctrl.opcode = ALU_SLL;  illegal = !f7_base; end
                    3'b010: begin ctrl.opcode = ALU_SLT;  illegal = !f7_base; end
                    3'b011: begin ctrl.opcode = ALU_SLTU; illegal = !f7_base; end
                    3'b100: begin ctrl.opcode = ALU_XOR;  illegal = !f7_base; end
                    3'b101: begin
                        ctrl.opcode = f7_alt ? ALU_SRA : ALU_SRL;
                        illegal     = !(f7_base || f7_alt);
                    end
                    3'b110: begin ctrl.opcode = ALU_OR;   illegal = !f7_base; end
                    default: begin ctrl.opcode = ALU_AND; illegal = !f7_base; end
                endcase
            end
            OPC_OP_IMM: begin
                // The ALU sign-extends the raw 12-bit immediate when sy is set.
                y       = {{(XLEN-12){1'b0}}, instr[31:20]};
                ctrl.sy = 1'b1;
                case (funct3)
                    3'b000: ctrl.opcode = ALU_ADD;
                    3'b010: ctrl.opcode = ALU_SLT;
                    3'b011: ctrl.opcode = ALU_SLTU;
                    3'b100: ctrl.opcode = ALU_XOR;
                    3'b110: ctrl.opcode = ALU_OR;
                    3'b111: ctrl.opcode = ALU_AND;
                    3'b001: begin
                        y           = {{(XLEN-5){1'b0}}, instr[24:20]};
                        ctrl.sy     = 1'b0;
                        ctrl.opcode = ALU_SLL;
                        illegal     = !f7_base;
                    end
                    default: begin
                        y           = {{(XLEN-5){1'b0}}, instr[24:20]};
                        ctrl.sy     = 1'b0;
                        ctrl.opcode = f7_alt ? ALU_SRA : ALU_SRL;
                        illegal     = !(f7_base || f7_alt);
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            x    = '0;
            y    = '0;
            ctrl = '0;
        end
    end

endmodule

// File: rtl/rv_alu_issue.sv
// Two-stage issue/retire around an external combinational ALU: s1 drives alu_*,
// s2 captures the result; 2-cycle latency, full throughput, stalls hold both stages.
module rv_alu_issue
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] alu_y,
    output logic            alu_nx,
    output logic            alu_ix,
    output logic            alu_sx,
    output logic            alu_ny,
    output logic            alu_iy,
    output logic            alu_sy,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_zero,
    output logic            res_illegal
);

    logic [XLEN-1:0] dec_x;
    logic [XLEN-1:0] dec_y;
    alu_ctrl_t       dec_ctrl;
    logic [4:0]      dec_rd;
    logic            dec_illegal;

    rv_alu_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .x       (dec_x),
        .y       (dec_y),
        .ctrl    (dec_ctrl),
        .rd      (dec_rd),
        .illegal (dec_illegal)
    );

    logic       s1_valid;
    alu_ctrl_t  s1_ctrl;
    logic [4:0] s1_rd;
    logic       s1_illegal;
    logic       s2_load;
    logic       accept;

    assign s2_load  = s1_valid && (!res_valid || res_ready);
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    assign alu_nx     = s1_ctrl.nx;
    assign alu_ix     = s1_ctrl.ix;
    assign alu_sx     = s1_ctrl.sx;
    assign alu_ny     = s1_ctrl.ny;
    assign alu_iy     = s1_ctrl.iy;
    assign alu_sy     = s1_ctrl.sy;
    assign alu_opcode = s1_ctrl.opcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            alu_x      <= '0;
            alu_y      <= '0;
            s1_ctrl    <= '0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                alu_x      <= dec_x;
                alu_y      <= dec_y;
                s1_ctrl    <= dec_ctrl;
                s1_rd      <= dec_rd;
                s1_illegal <= dec_illegal;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_zero    <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            if (s2_load) begin
                res_valid   <= 1'b1;
                res_data    <= s1_illegal ? '0 : alu_out;
                res_rd      <= s1_rd;
                res_zero    <= s1_illegal ? 1'b1 : alu_zero;
                res_illegal <= s1_illegal;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed bench for rv_alu_issue with a behavioural ALU closing the alu_* -> alu_out loop.
module tb_rv_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic        alu_nx, alu_ix, alu_sx, alu_ny, alu_iy, alu_sy;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_zero;
    logic        res_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_nx      (alu_nx),
        .alu_ix      (alu_ix),
        .alu_sx      (alu_sx),
        .alu_ny      (alu_ny),
        .alu_iy      (alu_iy),
        .alu_sy      (alu_sy),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_zero    (res_zero),
        .res_illegal (res_illegal)
    );

    // ALU model: sign-extend the low 12 bits, then invert, then increment.
    logic [31:0] ax;
    logic [31:0] ay;
    always_comb begin
        ax = alu_sx ? {{20{alu_x[11]}}, alu_x[11:0]} : alu_x;
        if (alu_nx) ax = ~ax;
        if (alu_ix) ax = ax + 32'd1;
        ay = alu_sy ? {{20{alu_y[11]}}, alu_y[11:0]} : alu_y;
        if (alu_ny) ay = ~ay;
        if (alu_iy) ay = ay + 32'd1;
        case (alu_opcode)
            4'd0:    alu_out = ax + ay;
            4'd1:    alu_out = ax - ay;
            4'd2:    alu_out = ax << ay[4:0];
            4'd3:    alu_out = ax >> ay[4:0];
            4'd4:    alu_out = $signed(ax) >>> ay[4:0];
            4'd5:    alu_out = {31'b0, $signed(ax) < $signed(ay)};
            4'd6:    alu_out = {31'b0, ax < ay};
            4'd7:    alu_out = {31'b0, ax == ay};
            4'd8:    alu_out = {31'b0, ax != ay};
            4'd9:    alu_out = {31'b0, $signed(ax) >= $signed(ay)};
            4'd10:   alu_out = {31'b0, ax >= ay};
            4'd11:   alu_out = ax & ay;
            4'd12:   alu_out = ax | ay;
            4'd13:   alu_out = ax ^ ay;
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    logic [31:0] s_instr [8];
    logic [31:0] s_rs1   [8];
    logic [31:0] s_rs2   [8];
    logic [31:0] s_exp   [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  idx;
        int  ridx;
        int  k;
        logic acc;
        logic ret;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        res_ready = 1'b1;
        repeat (2) step();
        chk("reset_res_valid", res_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_alu_opcode", alu_opcode, 0);
        chk("reset_alu_x", alu_x, 0);
        chk("reset_res_data", res_data, 0);
        reset = 1'b0;

        // ADDI x5, x1, -1 with rs1 = 0x10
        in_instr = enc_i(12'hFFF, 3'b000, 5'd5);
        in_rs1   = 32'h10;
        in_rs2   = 32'h0;
        in_valid = 1'b1;
        #1 chk("addi_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("addi_alu_y", alu_y, 32'h00000FFF);
        chk("addi_alu_sy", alu_sy, 1);
        chk("addi_alu_opcode", alu_opcode, 0);
        chk("addi_res_valid_early", res_valid, 0);
        step();
        chk("addi_res_valid", res_valid, 1);
        chk("addi_res_data", res_data, 32'h0000000F);
        chk("addi_res_rd", res_rd, 5);
        chk("addi_res_illegal", res_illegal, 0);
        step();
        chk("addi_res_drained", res_valid, 0);

        // SUB x6, 7 - 7
        in_instr = enc_r(7'h20, 3'b000, 5'd6);
        in_rs1   = 32'd7;
        in_rs2   = 32'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sub_alu_ny", alu_ny, 1);
        chk("sub_alu_iy", alu_iy, 1);
        chk("sub_alu_opcode", alu_opcode, 0);
        step();
        chk("sub_res_data", res_data, 0);
        chk("sub_res_zero", res_zero, 1);

        // SRAI x7, shamt 4, rs1 = 0x80000000
        in_instr = enc_i({7'h20, 5'd4}, 3'b101, 5'd7);
        in_rs1   = 32'h80000000;
        in_rs2   = 32'h0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("srai_alu_sy", alu_sy, 0);
        chk("srai_alu_y", alu_y, 4);
        chk("srai_alu_opcode", alu_opcode, 4);
        step();
        chk("srai_res_data", res_data, 32'hF8000000);
        chk("srai_res_rd", res_rd, 7);

        // MUL (illegal) followed back-to-back by ADD 1 + 2
        in_instr = enc_r(7'h01, 3'b000, 5'd8);
        in_rs1   = 32'd5;
        in_rs2   = 32'd6;
        in_valid = 1'b1;
        step();
        in_instr = enc_r(7'h00, 3'b000, 5'd9);
        in_rs1   = 32'd1;
        in_rs2   = 32'd2;
        step();
        in_valid = 1'b0;
        chk("mul_res_illegal", res_illegal, 1);
        chk("mul_res_data", res_data, 0);
        chk("mul_res_zero", res_zero, 1);
        chk("mul_res_rd", res_rd, 8);
        step();
        chk("after_mul_illegal", res_illegal, 0);
        chk("after_mul_data", res_data, 3);
        chk("after_mul_rd", res_rd, 9);
        step();

        // Stream of eight with res_ready low in cycles 3..5
        s_instr[0] = enc_r(7'h00, 3'b000, 5'd10); s_rs1[0] = 32'd3;        s_rs2[0] = 32'd4;    s_exp[0] = 32'd7;
        s_instr[1] = enc_r(7'h20, 3'b000, 5'd11); s_rs1[1] = 32'd10;       s_rs2[1] = 32'd3;    s_exp[1] = 32'd7;
        s_instr[2] = enc_r(7'h00, 3'b111, 5'd12); s_rs1[2] = 32'hF0F0;     s_rs2[2] = 32'hFF00; s_exp[2] = 32'hF000;
        s_instr[3] = enc_r(7'h00, 3'b110, 5'd13); s_rs1[3] = 32'hF0;       s_rs2[3] = 32'h0F;   s_exp[3] = 32'hFF;
        s_instr[4] = enc_r(7'h00, 3'b100, 5'd14); s_rs1[4] = 32'hFF;       s_rs2[4] = 32'h0F;   s_exp[4] = 32'hF0;
        s_instr[5] = enc_r(7'h00, 3'b010, 5'd15); s_rs1[5] = 32'hFFFFFFFF; s_rs2[5] = 32'd1;    s_exp[5] = 32'd1;
        s_instr[6] = enc_r(7'h00, 3'b011, 5'd16); s_rs1[6] = 32'hFFFFFFFF; s_rs2[6] = 32'd1;    s_exp[6] = 32'd0;
        s_instr[7] = enc_i({7'h00, 5'd3}, 3'b001, 5'd17); s_rs1[7] = 32'd5; s_rs2[7] = 32'd0;   s_exp[7] = 32'h28;
        idx  = 0;
        ridx = 0;
        k    = 0;
        while (ridx < 8 && k < 40) begin
            res_ready = !(k >= 3 && k <= 5);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                in_instr = s_instr[idx];
                in_rs1   = s_rs1[idx];
                in_rs2   = s_rs2[idx];
            end
            #1;
            chk("stream_in_ready", in_ready, !((idx - ridx) == 2 && !res_ready));
            if (res_valid) begin
                chk("stream_res_data", res_data, s_exp[ridx]);
                chk("stream_res_rd", res_rd, 32'(10 + ridx));
            end
            acc = in_valid && in_ready;
            ret = res_valid && res_ready;
            step();
            if (acc) idx++;
            if (ret) ridx++;
            k++;
        end
        chk("stream_all_retired", ridx, 8);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        #1 chk("stream_no_duplicate", res_valid, 0);

        // Reset with both stages full
        res_ready = 1'b0;
        in_instr  = enc_r(7'h00, 3'b100, 5'd11);
        in_rs1    = 32'hFF;
        in_rs2    = 32'h0F;
        in_valid  = 1'b1;
        step();
        in_instr = enc_r(7'h00, 3'b110, 5'd12);
        step();
        in_valid = 1'b0;
        chk("full_res_valid", res_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_alu_opcode", alu_opcode, 12);
        reset = 1'b1;
        step();
        chk("midreset_res_valid", res_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_alu_opcode", alu_opcode, 0);
        chk("midreset_alu_x", alu_x, 0);
        chk("midreset_res_data", res_data, 0);
        chk("midreset_res_rd", res_rd, 0);
        reset     = 1'b0;
        res_ready = 1'b1;
        step();
        chk("midreset_discarded", res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
